// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Ps3..Ps5 destination scoreboard, Ps2 stall, Ps3 forwarding selects, Ps4 multicycle freeze.
// Optional forwarding network enabled by defining HAZARD_FWD_EN; without it every in-flight RAW dependency stalls.
module hazard_ctrl #(
    parameter int MC_LAT = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       dec_valid_Ps2,
    input  logic [4:0] rs1_addr_Ps2,
    input  logic [4:0] rs2_addr_Ps2,
    input  logic       rs1_read_Ps2,
    input  logic       rs2_read_Ps2,
    input  logic [4:0] rd_Ps2,
    input  logic       rd_write_Ps2,
    input  logic       is_load_Ps2,
    input  logic       is_mc_Ps2,
    input  logic       flush_Ps4,
    output logic       stall_Ps2,
    output logic       freeze_Ps4,
    output logic [1:0] fwd_rs1_Ps3,
    output logic [1:0] fwd_rs2_Ps3,
    output logic       mc_busy
);

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
        logic       ld;
        logic       mc;
    } s3_slot_t;

    // Older slots only need what the source comparison looks at.
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
    } trk_slot_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [5:0] CNT_LOAD = (MC_LAT > 1) ? 6'(MC_LAT - 2) : 6'd0;
    localparam logic       MC_EN    = (MC_LAT > 1) ? 1'b1 : 1'b0;

    function automatic logic src_match(input logic used, input logic [4:0] addr,
                                       input logic valid, input logic wr, input logic [4:0] rd);
        return used & (addr != 5'd0) & valid & wr & (rd == addr);
    endfunction

    s3_slot_t  s3_r;
    s3_slot_t  new_s3_s;
    trk_slot_t s4_r;
    trk_slot_t s5_r;
    state_t    state_r;
    state_t    state_nxt_s;
    logic [5:0] cnt_r;
    logic [5:0] cnt_nxt_s;
    logic       freeze_s;
    logic       hazard_s;
    logic       take_s;
    logic       m1_s3_s, m1_s4_s, m1_s5_s;
    logic       m2_s3_s, m2_s4_s, m2_s5_s;

    assign m1_s3_s = src_match(rs1_read_Ps2, rs1_addr_Ps2, s3_r.valid, s3_r.wr, s3_r.rd);
    assign m1_s4_s = src_match(rs1_read_Ps2, rs1_addr_Ps2, s4_r.valid, s4_r.wr, s4_r.rd);
    assign m1_s5_s = src_match(rs1_read_Ps2, rs1_addr_Ps2, s5_r.valid, s5_r.wr, s5_r.rd);
    assign m2_s3_s = src_match(rs2_read_Ps2, rs2_addr_Ps2, s3_r.valid, s3_r.wr, s3_r.rd);
    assign m2_s4_s = src_match(rs2_read_Ps2, rs2_addr_Ps2, s4_r.valid, s4_r.wr, s4_r.rd);
    assign m2_s5_s = src_match(rs2_read_Ps2, rs2_addr_Ps2, s5_r.valid, s5_r.wr, s5_r.rd);

    assign freeze_s   = (state_r == BUSY);
    assign freeze_Ps4 = freeze_s;
    assign mc_busy    = freeze_s;
    assign stall_Ps2  = (hazard_s | freeze_s) & ~flush_Ps4;
    assign take_s     = dec_valid_Ps2 & ~stall_Ps2 & ~flush_Ps4;

`ifdef HAZARD_FWD_EN
    logic [1:0] sel1_s;
    logic [1:0] sel2_s;
    logic [1:0] fwd1_r;
    logic [1:0] fwd2_r;

    // Only a load still in Ps3 cannot be forwarded in time.
    assign hazard_s = (m1_s3_s | m2_s3_s) & s3_r.ld;

    // Youngest matching producer wins the forward select.
    always_comb begin
        sel1_s = 2'd0;
        sel2_s = 2'd0;
        if (m1_s3_s)      sel1_s = 2'd1;
        else if (m1_s4_s) sel1_s = 2'd2;
        else if (m1_s5_s) sel1_s = 2'd3;
        else              sel1_s = 2'd0;
        if (m2_s3_s)      sel2_s = 2'd1;
        else if (m2_s4_s) sel2_s = 2'd2;
        else if (m2_s5_s) sel2_s = 2'd3;
        else              sel2_s = 2'd0;
    end

    // Forward selects travel with the instruction entering Ps3.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd1_r <= 2'd0;
            fwd2_r <= 2'd0;
        end else if (freeze_s) begin
            fwd1_r <= fwd1_r;
            fwd2_r <= fwd2_r;
        end else if (take_s) begin
            fwd1_r <= sel1_s;
            fwd2_r <= sel2_s;
        end else begin
            fwd1_r <= 2'd0;
            fwd2_r <= 2'd0;
        end
    end

    assign fwd_rs1_Ps3 = fwd1_r;
    assign fwd_rs2_Ps3 = fwd2_r;
`else
    logic unused_ld_s;

    assign hazard_s    = m1_s3_s | m1_s4_s | m1_s5_s | m2_s3_s | m2_s4_s | m2_s5_s;
    assign unused_ld_s = s3_r.ld;
    assign fwd_rs1_Ps3 = 2'd0;
    assign fwd_rs2_Ps3 = 2'd0;
`endif

    // Candidate S3 entry; x0 destinations are never tracked.
    always_comb begin
        new_s3_s = '0;
        if (take_s) begin
            new_s3_s.valid = 1'b1;
            new_s3_s.wr    = rd_write_Ps2 & (rd_Ps2 != 5'd0);
            new_s3_s.rd    = rd_Ps2;
            new_s3_s.ld    = is_load_Ps2;
            new_s3_s.mc    = is_mc_Ps2;
        end else begin
            new_s3_s = '0;
        end
    end

    // Scoreboard advance; a freeze holds S3/S4 and drops a bubble into S5.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_r <= '0;
            s4_r <= '0;
            s5_r <= '0;
        end else if (freeze_s) begin
            s5_r <= '0;
        end else begin
            s5_r <= s4_r;
            s4_r <= {s3_r.valid, s3_r.wr, s3_r.rd};
            s3_r <= new_s3_s;
        end
    end

    // Multicycle FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Multicycle FSM next state; flush is ignored while the op occupies Ps4.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (MC_EN & s3_r.valid & s3_r.mc & ~flush_Ps4) begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 6'd0) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 6'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 6'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a pipeline-occupancy model predicts outputs per cycle, a negedge monitor compares.
module tb_hazard_ctrl;
    localparam int MC_LAT = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       dec_valid_Ps2, rs1_read_Ps2, rs2_read_Ps2, rd_write_Ps2;
    logic       is_load_Ps2, is_mc_Ps2, flush_Ps4;
    logic [4:0] rs1_addr_Ps2, rs2_addr_Ps2, rd_Ps2;
    logic       stall_Ps2, freeze_Ps4, mc_busy;
    logic [1:0] fwd_rs1_Ps3, fwd_rs2_Ps3;

    hazard_ctrl #(.MC_LAT(MC_LAT)) dut (
        .clk(clk), .rstn(rstn),
        .dec_valid_Ps2(dec_valid_Ps2),
        .rs1_addr_Ps2(rs1_addr_Ps2), .rs2_addr_Ps2(rs2_addr_Ps2),
        .rs1_read_Ps2(rs1_read_Ps2), .rs2_read_Ps2(rs2_read_Ps2),
        .rd_Ps2(rd_Ps2), .rd_write_Ps2(rd_write_Ps2),
        .is_load_Ps2(is_load_Ps2), .is_mc_Ps2(is_mc_Ps2),
        .flush_Ps4(flush_Ps4),
        .stall_Ps2(stall_Ps2), .freeze_Ps4(freeze_Ps4),
        .fwd_rs1_Ps3(fwd_rs1_Ps3), .fwd_rs2_Ps3(fwd_rs2_Ps3),
        .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] r1;
        logic       u1;
        logic [4:0] r2;
        logic       u2;
        logic [4:0] rd;
        logic       w;
        logic       ld;
        logic       mc;
    } ins_t;

    typedef struct packed {
        logic       stall;
        logic       freeze;
        logic       busy;
        logic [1:0] f1;
        logic [1:0] f2;
    } exp_t;

    // One instruction resident in a pipeline stage; dest 0 means it produces nothing trackable.
    typedef struct packed {
        logic       live;
        logic [4:0] dest;
        logic       ld;
        logic       mc;
    } stg_t;

    exp_t       exp_q[$];
    stg_t       stg[3:5];
    int         mc_left;
    logic [1:0] m_f1, m_f2;
    int         checks = 0;
    int         failures = 0;

    function automatic ins_t mk(input int r1, input int u1, input int r2, input int u2,
                                input int rd, input int w, input int ld, input int mc);
        ins_t i;
        i.v  = 1'b1;
        i.r1 = 5'(r1);  i.u1 = (u1 != 0);
        i.r2 = 5'(r2);  i.u2 = (u2 != 0);
        i.rd = 5'(rd);  i.w  = (w != 0);
        i.ld = (ld != 0);
        i.mc = (mc != 0);
        return i;
    endfunction

    // Stage number (3..5) of the youngest in-flight producer of src, 0 if none.
    function automatic int youngest(input logic used, input logic [4:0] src);
        for (int k = 3; k <= 5; k++)
            if (used && src != 5'd0 && stg[k].live && stg[k].dest == src) return k;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 3; k <= 5; k++) stg[k] = '0;
        mc_left = 0;
        m_f1 = 2'd0;
        m_f2 = 2'd0;
    endtask

    task automatic drive(input ins_t i, input logic fl);
        dec_valid_Ps2 = i.v;
        rs1_addr_Ps2  = i.r1;  rs1_read_Ps2 = i.u1;
        rs2_addr_Ps2  = i.r2;  rs2_read_Ps2 = i.u2;
        rd_Ps2        = i.rd;  rd_write_Ps2 = i.w;
        is_load_Ps2   = i.ld;  is_mc_Ps2    = i.mc;
        flush_Ps4     = fl;
    endtask

    // One cycle: drive, predict, queue expectation, then advance the model at the edge.
    task automatic step(input ins_t i, input logic fl, output logic stalled);
        int y1, y2;
        logic haz, st, frz;
        logic [1:0] s1, s2;
        exp_t e;
        drive(i, fl);
        y1 = youngest(i.u1, i.r1);
        y2 = youngest(i.u2, i.r2);
`ifdef HAZARD_FWD_EN
        haz = ((y1 == 3) || (y2 == 3)) && stg[3].ld;
        s1  = (y1 == 0) ? 2'd0 : 2'(y1 - 2);
        s2  = (y2 == 0) ? 2'd0 : 2'(y2 - 2);
`else
        haz = (y1 != 0) || (y2 != 0);
        s1  = 2'd0;
        s2  = 2'd0;
`endif
        frz = (mc_left > 0);
        st  = (haz || frz) && !fl;
        e.stall = st;  e.freeze = frz;  e.busy = frz;
        e.f1 = m_f1;   e.f2 = m_f2;
        exp_q.push_back(e);
        stalled = st;
        @(posedge clk);
        if (frz) begin
            stg[5] = '0;
            mc_left = mc_left - 1;
        end else begin
            if (stg[3].live && stg[3].mc && !fl && MC_LAT > 1) mc_left = MC_LAT - 1;
            stg[5] = stg[4];
            stg[4] = stg[3];
            if (i.v && !st && !fl) begin
                stg[3].live = 1'b1;
                stg[3].dest = i.w ? i.rd : 5'd0;
                stg[3].ld   = i.ld;
                stg[3].mc   = i.mc;
                m_f1 = s1;
                m_f2 = s2;
            end else begin
                stg[3] = '0;
                m_f1 = 2'd0;
                m_f2 = 2'd0;
            end
        end
        #1;
    endtask

    // Present an instruction until the model says it left Ps2 (flush only on the first try).
    task automatic issue(input ins_t i, input logic fl);
        logic s;
        int n;
        n = 0;
        step(i, fl, s);
        while (s && n < 64) begin
            step(i, 1'b0, s);
            n++;
        end
    endtask

    task automatic nops(input int n);
        logic s;
        for (int k = 0; k < n; k++) step('0, 1'b0, s);
    endtask

    // Reset is asserted between edges, so a zero freeze at the next negedge proves it is asynchronous.
    task automatic do_reset(input int n);
        exp_t z;
        z = '0;
        rstn = 1'b0;
        drive('0, 1'b0);
        model_clear();
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(z);
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_Ps2",   {1'b0, stall_Ps2},  {1'b0, e.stall});
            chk("freeze_Ps4",  {1'b0, freeze_Ps4}, {1'b0, e.freeze});
            chk("mc_busy",     {1'b0, mc_busy},    {1'b0, e.busy});
            chk("fwd_rs1_Ps3", fwd_rs1_Ps3, e.f1);
            chk("fwd_rs2_Ps3", fwd_rs2_Ps3, e.f2);
        end
    end

    initial begin
        ins_t ri;
        logic rf;
        drive('0, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        do_reset(2);

        // ALU back-to-back: addi x5,x0,1 ; add x6,x5,x5
        issue(mk(0, 1, 0, 0, 5, 1, 0, 0), 1'b0);
        issue(mk(5, 1, 5, 1, 6, 1, 0, 0), 1'b0);
        nops(4);
        // Load-use: lw x7,0(x0) ; add x8,x7,x0
        issue(mk(0, 1, 0, 0, 7, 1, 1, 0), 1'b0);
        issue(mk(7, 1, 0, 1, 8, 1, 0, 0), 1'b0);
        nops(4);
        // x0 is never a dependency: addi x0,x0,5 ; add x1,x0,x0
        issue(mk(0, 1, 0, 0, 0, 1, 0, 0), 1'b0);
        issue(mk(0, 1, 0, 1, 1, 1, 0, 0), 1'b0);
        nops(4);
        // Multicycle: div x9 ; add x10,x9,x9
        issue(mk(1, 1, 2, 1, 9, 1, 0, 1), 1'b0);
        issue(mk(9, 1, 9, 1, 10, 1, 0, 0), 1'b0);
        nops(8);
        // Flush coincident with a load-use hazard
        issue(mk(0, 1, 0, 0, 7, 1, 1, 0), 1'b0);
        issue(mk(7, 1, 0, 1, 8, 1, 0, 0), 1'b1);
        nops(4);
        // Reset during the second BUSY cycle of a div
        issue(mk(1, 1, 2, 1, 11, 1, 0, 1), 1'b0);
        nops(2);
        do_reset(2);
        issue(mk(11, 1, 11, 1, 12, 1, 0, 0), 1'b0);
        nops(3);

        // Random traffic over a small register window so dependencies are frequent.
        for (int n = 0; n < 1500; n++) begin
            ri = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0);
            ri.v = ($urandom_range(0, 7) != 0);
            rf   = ($urandom_range(0, 9) == 0);
            issue(ri, rf);
            if (n == 700) do_reset(1);
        end
        nops(8);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I core. It tracks in-flight destination registers from Ps3 to Ps5 in a scoreboard and compares them against the Ps2 decode source operands. From that comparison it produces Ps2 stall, registered forwarding selects for the Ps3 operands, and a freeze for multicycle (M-extension) ops held in Ps4. The register file's Ps6 write-through bypass covers producers in Ps6, so this block never tracks Ps6.

## Interface
- MC_LAT, 32: Ps4 occupancy in cycles of a multicycle op; legal range 1..64; 1 = no freeze.
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- dec_valid_Ps2  in  1  Ps2 holds a real instruction.
- rs1_addr_Ps2, rs2_addr_Ps2  in  5  source register indices.
- rs1_read_Ps2, rs2_read_Ps2  in  1  source is actually used.
- rd_Ps2  in  5  destination index.
- rd_write_Ps2  in  1  instruction writes rd.
- is_load_Ps2  in  1  load; data is valid at the Ps5 output.
- is_mc_Ps2  in  1  multicycle op.
- flush_Ps4  in  1  branch redirect resolved in Ps4; kills Ps2 and Ps3.
- stall_Ps2  out  1  hold PC/Ps1/Ps2 and inject a bubble into Ps3.
- freeze_Ps4  out  1  hold Ps1..Ps4 and inject a bubble into Ps5.
- fwd_rs1_Ps3, fwd_rs2_Ps3  out  2  registered operand source: 0 regfile, 1 Ps4 result, 2 Ps5 result, 3 Ps6 result.
- mc_busy  out  1  FSM is in BUSY.

## Operation
- Scoreboard slots S3, S4 and S5. Each slot holds {valid, wr, rd, ld, mc}. A slot has wr=0 whenever rd==0; x0 is never tracked.
- Slot advance rules:
  - No freeze: S5<=S4, S4<=S3, S3<=new.
  - Freeze: S3 and S4 hold; S5<=invalid.
- S3 new value:
  - Ps2 fields, when dec_valid_Ps2 & ~stall_Ps2 & ~flush_Ps4.
  - Otherwise invalid.
- Match for a source: rsX_read & rsX_addr!=0 & slot.valid & slot.wr & slot.rd==rsX_addr.
- Hazard with forwarding:
  - Any source matches S3 with S3.ld=1 (load-use). S3 is the youngest slot, so it is checked first.
- Forward select for each source (youngest match wins):
  - S3 match -> 1.
  - Else S4 match -> 2.
  - Else S5 match -> 3.
  - Else 0.
- stall_Ps2 = (hazard | freeze_Ps4) & ~flush_Ps4. Flush has priority over stall.
- Forward-select register:
  - Loaded with the computed selects when S3 takes a valid new entry.
  - Cleared to 0 when a bubble enters S3.
  - Held during freeze.
- FSM states IDLE and BUSY, with a 6-bit counter cnt.
  - IDLE -> BUSY when S3.valid & S3.mc & ~freeze_Ps4 & ~flush_Ps4 & MC_LAT>1; cnt<=MC_LAT-2.
  - BUSY: if cnt==0 go to IDLE, else cnt<=cnt-1.
  - flush_Ps4 is ignored in BUSY, because Ps4 holds the mc op.
- freeze_Ps4 = mc_busy = (state==BUSY). Both are combinational from the state register.

## Timing
- Reset (asynchronous): all slots invalid, FSM IDLE, cnt=0, fwd selects 0, stall_Ps2=0, freeze_Ps4=0, mc_busy=0.
- stall_Ps2 is combinational from Ps2 inputs and registered state, in the same cycle.
- Forward selects appear one cycle after the consumer's Ps2 cycle, aligned with the consumer's Ps3 cycle.
- Load-use costs a 1-cycle stall, then select 2.
- ALU back-to-back costs 0 cycles, with select 1.
- A multicycle op entering Ps4 in cycle t asserts freeze_Ps4 in cycles t..t+MC_LAT-2, i.e. for MC_LAT-1 cycles. The Ps4 result is valid in cycle t+MC_LAT-1 and advances at the end of that cycle.
- Reset asserted mid-BUSY: freeze_Ps4 drops immediately (asynchronous) and the scoreboard is cleared.
- Simultaneous flush and hazard: stall_Ps2=0, S3<=invalid, selects<=0.

## Configuration
- HAZARD_FWD_EN defined: forwarding behaves as described above.
- HAZARD_FWD_EN undefined:
  - fwd_rs1_Ps3 and fwd_rs2_Ps3 are tied to 0.
  - hazard = any source match in S3, S4 or S5, regardless of ld.
  - Operands come only from the register file and its Ps6 bypass.

## Test plan
- FWD_EN, `addi x5,x0,1` then `add x6,x5,x5` -> stall_Ps2 never high; fwd_rs1_Ps3=fwd_rs2_Ps3=1 in the add's Ps3 cycle.
- FWD_EN, `lw x7` then `add x8,x7,x0` -> stall_Ps2=1 for exactly 1 cycle; then fwd_rs1_Ps3=2, fwd_rs2_Ps3=0.
- `addi x0,x0,5` then `add x1,x0,x0` -> no stall; selects 0, including with FWD_EN undefined.
- MC_LAT=4, `div x9` then dependent `add x10,x9,x9`:
  - freeze_Ps4=mc_busy=1 for 3 cycles, starting when the div enters Ps4.
  - add's selects=1, held through the freeze.
  - S5 receives 3 bubbles.
- flush_Ps4=1 in the same cycle as a load-use hazard -> stall_Ps2=0; next cycle S3 invalid and selects 0.
- rstn low during the 2nd BUSY cycle (MC_LAT=8) -> freeze_Ps4=0 immediately; after release, state IDLE and no stall.
- FWD_EN undefined, `addi x5` then `add x6,x5,x5` -> stall_Ps2=1 for 3 cycles; selects stay 0.
